// File: rtl/ssd_window_engine.sv
// Block-matching cost engine: per-row SSD/SAD between left and right pixel slices,
// summed over a window of row beats through a four-stage pipeline.
module ssd_window_engine #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int NUM_PIXELS      = 6,
    parameter int ROWS_PER_WINDOW = 6,
    localparam longint unsigned MAX_PIX = (64'd1 << PIXEL_WIDTH) - 64'd1,
    localparam int ACC_WIDTH = $clog2(64'(ROWS_PER_WINDOW) * 64'(NUM_PIXELS) * MAX_PIX * MAX_PIX + 64'd1),
    localparam int IDX_WIDTH = $clog2(ROWS_PER_WINDOW + 1),
    localparam int ROW_WIDTH = NUM_PIXELS * PIXEL_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [ROW_WIDTH-1:0] left_row,
    input  logic [ROW_WIDTH-1:0] right_row,
    input  logic                 valid_in,
    input  logic                 sad_mode_in,
    input  logic                 clear_in,
    output logic [ACC_WIDTH-1:0] window_cost,
    output logic                 valid_out,
    output logic [IDX_WIDTH-1:0] row_idx
);

    logic [IDX_WIDTH-1:0] row_idx_q, row_idx_d;
    logic                 mode_q, mode_d;

    logic                                   s1_valid_q, s1_valid_d;
    logic                                   s1_mode_q, s1_mode_d;
    logic                                   s1_last_q, s1_last_d;
    logic [NUM_PIXELS-1:0][PIXEL_WIDTH-1:0] s1_diff_q, s1_diff_d;

    logic                                     s2_valid_q, s2_valid_d;
    logic                                     s2_last_q, s2_last_d;
    logic [NUM_PIXELS-1:0][2*PIXEL_WIDTH-1:0] s2_metric_q, s2_metric_d;

    logic                 s3_valid_q, s3_valid_d;
    logic                 s3_last_q, s3_last_d;
    logic [ACC_WIDTH-1:0] s3_sum_q, s3_sum_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] window_cost_q, window_cost_d;
    logic                 valid_out_q, valid_out_d;

    logic beat_last;
    logic beat_mode;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
            logic [PIXEL_WIDTH-1:0]   l_pix;
            logic [PIXEL_WIDTH-1:0]   r_pix;
            logic [2*PIXEL_WIDTH-1:0] diff_ext;

            // Pixel 0 sits in the most significant slot of the packed row.
            assign l_pix = left_row[(NUM_PIXELS-1-gi)*PIXEL_WIDTH +: PIXEL_WIDTH];
            assign r_pix = right_row[(NUM_PIXELS-1-gi)*PIXEL_WIDTH +: PIXEL_WIDTH];
            assign s1_diff_d[gi] = (l_pix >= r_pix) ? (l_pix - r_pix) : (r_pix - l_pix);

            assign diff_ext = {{PIXEL_WIDTH{1'b0}}, s1_diff_q[gi]};
            assign s2_metric_d[gi] = s1_mode_q ? diff_ext : (diff_ext * diff_ext);
        end
    endgenerate

    always_comb begin
        beat_last = (row_idx_q == IDX_WIDTH'(ROWS_PER_WINDOW - 1));
        // The first row of a window takes the live mode; later rows reuse the latched one.
        beat_mode = (row_idx_q == '0) ? sad_mode_in : mode_q;

        row_idx_d = row_idx_q;
        mode_d    = mode_q;
        if (clear_in) begin
            row_idx_d = '0;
        end else if (valid_in) begin
            mode_d    = beat_mode;
            row_idx_d = beat_last ? '0 : (row_idx_q + IDX_WIDTH'(1));
        end

        s1_valid_d = valid_in && !clear_in;
        s1_mode_d  = beat_mode;
        s1_last_d  = beat_last;

        s2_valid_d = s1_valid_q && !clear_in;
        s2_last_d  = s1_last_q;

        s3_valid_d = s2_valid_q && !clear_in;
        s3_last_d  = s2_last_q;
        s3_sum_d   = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            s3_sum_d = s3_sum_d + ACC_WIDTH'(s2_metric_q[i]);
        end

        acc_d         = acc_q;
        window_cost_d = window_cost_q;
        valid_out_d   = 1'b0;
        if (s3_valid_q) begin
            if (s3_last_q) begin
                window_cost_d = acc_q + s3_sum_q;
                valid_out_d   = 1'b1;
                acc_d         = '0;
            end else begin
                acc_d = acc_q + s3_sum_q;
            end
        end
        if (clear_in) begin
            acc_d       = '0;
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_idx_q     <= '0;
            mode_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_mode_q     <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_diff_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_metric_q   <= '0;
            s3_valid_q    <= 1'b0;
            s3_last_q     <= 1'b0;
            s3_sum_q      <= '0;
            acc_q         <= '0;
            window_cost_q <= '0;
            valid_out_q   <= 1'b0;
        end else begin
            row_idx_q     <= row_idx_d;
            mode_q        <= mode_d;
            s1_valid_q    <= s1_valid_d;
            s1_mode_q     <= s1_mode_d;
            s1_last_q     <= s1_last_d;
            s1_diff_q     <= s1_diff_d;
            s2_valid_q    <= s2_valid_d;
            s2_last_q     <= s2_last_d;
            s2_metric_q   <= s2_metric_d;
            s3_valid_q    <= s3_valid_d;
            s3_last_q     <= s3_last_d;
            s3_sum_q      <= s3_sum_d;
            acc_q         <= acc_d;
            window_cost_q <= window_cost_d;
            valid_out_q   <= valid_out_d;
        end
    end

    assign window_cost = window_cost_q;
    assign valid_out   = valid_out_q;
    assign row_idx     = row_idx_q;

endmodule

// File: tb/tb_ssd_window_engine.sv
// Directed bench for ssd_window_engine: hand-computed window costs, pulse counts and latency.
module tb_ssd_window_engine;

    localparam int AW = 22;
    localparam int IW = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [47:0]   left_row;
    logic [47:0]   right_row;
    logic          valid_in;
    logic          sad_mode_in;
    logic          clear_in;
    logic [AW-1:0] window_cost;
    logic          valid_out;
    logic [IW-1:0] row_idx;

    int n_vec = 0;
    int n_bad = 0;
    int ncyc  = 0;
    int last_stamp = 0;
    logic [31:0] cost_q[$];
    int          stamp_q[$];

    ssd_window_engine dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .left_row    (left_row),
        .right_row   (right_row),
        .valid_in    (valid_in),
        .sad_mode_in (sad_mode_in),
        .clear_in    (clear_in),
        .window_cost (window_cost),
        .valid_out   (valid_out),
        .row_idx     (row_idx)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) ncyc <= ncyc + 1;

    // Every cycle with valid_out high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            cost_q.push_back(32'(window_cost));
            stamp_q.push_back(ncyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic put(input logic [47:0] l, input logic [47:0] r,
                       input logic m, input logic v, input logic c);
        @(negedge clk_in);
        left_row    = l;
        right_row   = r;
        sad_mode_in = m;
        valid_in    = v;
        clear_in    = c;
        if (v) last_stamp = ncyc;
    endtask

    task automatic idle(input int n);
        repeat (n) put(48'h0, 48'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rows(input logic [47:0] l, input logic [47:0] r, input logic m, input int n);
        repeat (n) put(l, r, m, 1'b1, 1'b0);
    endtask

    task automatic expect_pulse(input string tag, input logic [31:0] exp_cost, input int exp_stamp);
        logic [31:0] c;
        int          s;
        if (cost_q.size() > 0) begin
            c = cost_q.pop_front();
            s = stamp_q.pop_front();
            check_val({tag, " cost"}, c, exp_cost);
            check_val({tag, " cycle"}, 32'(s), 32'(exp_stamp));
        end else begin
            check_val({tag, " present"}, 32'(cost_q.size()), 32'd1);
        end
    endtask

    initial begin
        int a;
        int b;
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        clear_in    = 1'b0;
        sad_mode_in = 1'b0;
        left_row    = '0;
        right_row   = '0;
        repeat (3) @(negedge clk_in);
        check_val("reset window_cost", 32'(window_cost), 32'd0);
        check_val("reset valid_out", 32'(valid_out), 32'd0);
        check_val("reset row_idx", 32'(row_idx), 32'd0);
        rst_in = 1'b0;

        // Full-scale SSD: 36 * 255^2
        rows(48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 6);
        a = last_stamp;
        idle(8);
        check_val("ssd max pulses", 32'(cost_q.size()), 32'd1);
        expect_pulse("ssd max", 32'd2340900, a + 4);
        check_val("ssd max row_idx", 32'(row_idx), 32'd0);
        check_val("ssd max held", 32'(window_cost), 32'd2340900);

        // SAD latched on the first row, mode input toggled afterwards: 36 * 255
        put(48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, 1'b1, 1'b0);
        rows(48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 5);
        a = last_stamp;
        idle(8);
        check_val("sad latch pulses", 32'(cost_q.size()), 32'd1);
        expect_pulse("sad latch", 32'd9180, a + 4);

        // Back-to-back windows: 36 then 6 * 100
        rows(48'h0101_0101_0101, 48'h0, 1'b0, 6);
        a = last_stamp;
        rows(48'h0A00_0000_0000, 48'h0, 1'b0, 6);
        b = last_stamp;
        idle(8);
        check_val("b2b pulses", 32'(cost_q.size()), 32'd2);
        expect_pulse("b2b win A", 32'd36, a + 4);
        expect_pulse("b2b win B", 32'd600, b + 4);

        // Gapped beats: 36 * 3^2
        repeat (6) begin
            put(48'h0A0A_0A0A_0A0A, 48'h0D0D_0D0D_0D0D, 1'b0, 1'b1, 1'b0);
            idle(3);
        end
        a = last_stamp;
        idle(8);
        check_val("gaps pulses", 32'(cost_q.size()), 32'd1);
        expect_pulse("gaps", 32'd324, a + 4);

        // Abort after 3 rows (clear coincides with a dropped beat), then a full window: 36 * 2^2
        rows(48'h0202_0202_0202, 48'h0, 1'b0, 3);
        idle(1);
        check_val("clear pre row_idx", 32'(row_idx), 32'd3);
        put(48'h0202_0202_0202, 48'h0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check_val("clear post row_idx", 32'(row_idx), 32'd0);
        rows(48'h0202_0202_0202, 48'h0, 1'b0, 6);
        a = last_stamp;
        idle(8);
        check_val("clear pulses", 32'(cost_q.size()), 32'd1);
        expect_pulse("clear next win", 32'd144, a + 4);

        // Reset coincident with the 4th beat, then an equal-pixel window
        rows(48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 3);
        put(48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 1'b1, 1'b0);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        check_val("midrst window_cost", 32'(window_cost), 32'd0);
        check_val("midrst valid_out", 32'(valid_out), 32'd0);
        check_val("midrst row_idx", 32'(row_idx), 32'd0);
        idle(8);
        check_val("midrst pulses", 32'(cost_q.size()), 32'd0);
        rows(48'h5A5A_5A5A_5A5A, 48'h5A5A_5A5A_5A5A, 1'b0, 6);
        a = last_stamp;
        idle(8);
        check_val("equal pulses", 32'(cost_q.size()), 32'd1);
        expect_pulse("equal", 32'd0, a + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
